// File: rtl/if_fetch_unit_pkg.sv
// Shared types for the MIPS32 instruction-fetch stage: FSM states, NOP encoding, IF/ID bundle.
package mips32_if_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0000;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] instr;
   } ifid_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and imem (slave).
interface if_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (output req, output addr, input ack, input rdata);
   modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/if_fetch_unit_if_id_reg.sv
// IF/ID pipeline register: flush-to-NOP beats load, load beats bubble, otherwise hold.
module if_id_reg
   import mips32_if_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load_i,
   input  logic  flush_i,
   input  logic  bubble_i,
   input  ifid_t d_i,
   output ifid_t q_o
);

   ifid_t q_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q.valid <= 1'b0;
         q_q.pc    <= 32'h0000_0000;
         q_q.instr <= INSTR_NOP;
      end else if (flush_i) begin
         q_q.valid <= 1'b0;
         q_q.instr <= INSTR_NOP;
      end else if (load_i) begin
         q_q <= d_i;
      end else if (bubble_i) begin
         q_q.valid <= 1'b0;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS32 instruction-fetch stage: PC, imem request sequencing, skid buffer and IF/ID load.
// Optional misaligned-fetch trap enabled by defining IF_MISALIGN_TRAP_EN.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request outstanding at imem_addr = pc
// HOLD  | response captured in skid while ID stalls, no request
// DRAIN | flushed while waiting; swallow the stale response
module if_fetch_unit
   import mips32_if_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [31:0]            next_pc,
   output logic [31:0]            pc_plus4,
   output logic [31:0]            pc,
   if_fetch_unit_if.master        imem,
   input  logic                   stall_id,
   input  logic                   flush,
   output logic                   ifid_valid,
   output logic [31:0]            ifid_pc,
   output logic [31:0]            ifid_instr,
   output logic                   misalign_exc
);

   fetch_state_e state_q;
   logic [31:0]  pc_q;
   logic [31:0]  addr_q;
   logic         req_q;
   logic [31:0]  skid_q;
   logic         skid_vld_q;
   logic         misalign_q;

   logic         trap;
   logic [31:0]  pc_load;
   logic         ifid_load;
   logic         ifid_flush;
   logic         ifid_bubble;
   ifid_t        ifid_d;
   ifid_t        ifid_q;

`ifdef IF_MISALIGN_TRAP_EN
   assign trap = (next_pc[1:0] != 2'b00);
`else
   assign trap = 1'b0;
`endif

   // Without the trap, low bits are simply dropped so fetches stay word-aligned.
   assign pc_load = trap ? EXC_VECTOR : (next_pc & 32'hFFFF_FFFC);

   always_comb begin
      ifid_load    = 1'b0;
      ifid_flush   = 1'b0;
      ifid_bubble  = 1'b0;
      ifid_d.valid = 1'b1;
      ifid_d.pc    = pc_q;
      ifid_d.instr = imem.rdata;
      if (flush) begin
         ifid_flush = 1'b1;
      end else begin
         case (state_q)
            FETCH: begin
               if (imem.ack && !stall_id)       ifid_load   = 1'b1;
               else if (!imem.ack && !stall_id) ifid_bubble = 1'b1;
            end
            HOLD: begin
               if (!stall_id) begin
                  ifid_load    = 1'b1;
                  ifid_d.valid = skid_vld_q;
                  ifid_d.instr = skid_q;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VECTOR;
         addr_q     <= RESET_VECTOR;
         req_q      <= 1'b0;
         skid_q     <= INSTR_NOP;
         skid_vld_q <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= 1'b0;
         if (flush) begin
            pc_q       <= pc_load;
            misalign_q <= trap;
            skid_vld_q <= 1'b0;
            req_q      <= 1'b1;
            // An unanswered request must stay on the bus until its ack arrives.
            if ((state_q == FETCH || state_q == DRAIN) && !imem.ack) begin
               state_q <= DRAIN;
            end else begin
               state_q <= FETCH;
               addr_q  <= pc_load;
            end
         end else begin
            case (state_q)
               BOOT: begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= pc_q;
               end
               FETCH: begin
                  if (imem.ack) begin
                     if (stall_id) begin
                        skid_q     <= imem.rdata;
                        skid_vld_q <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= HOLD;
                     end else begin
                        pc_q       <= pc_load;
                        addr_q     <= pc_load;
                        misalign_q <= trap;
                     end
                  end
               end
               HOLD: begin
                  if (!stall_id) begin
                     pc_q       <= pc_load;
                     addr_q     <= pc_load;
                     misalign_q <= trap;
                     req_q      <= 1'b1;
                     skid_vld_q <= 1'b0;
                     state_q    <= FETCH;
                  end
               end
               DRAIN: begin
                  if (imem.ack) begin
                     addr_q  <= pc_q;
                     state_q <= FETCH;
                  end
               end
               default: state_q <= BOOT;
            endcase
         end
      end
   end

   if_id_reg u_if_id_reg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (ifid_load),
      .flush_i  (ifid_flush),
      .bubble_i (ifid_bubble),
      .d_i      (ifid_d),
      .q_o      (ifid_q)
   );

   assign pc           = pc_q;
   assign pc_plus4     = pc_q + 32'd4;
   assign imem.req     = req_q;
   assign imem.addr    = addr_q;
   assign ifid_valid   = ifid_q.valid;
   assign ifid_pc      = ifid_q.pc;
   assign ifid_instr   = ifid_q.instr;
   assign misalign_exc = misalign_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed testbench for if_fetch_unit; instruction words are {16'hC0DE, addr[15:0]}.
module tb_if_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
   logic [31:0] pc;
   logic        stall_id;
   logic        flush;
   logic        ifid_valid;
   logic [31:0] ifid_pc;
   logic [31:0] ifid_instr;
   logic        misalign_exc;

   logic        zw_mode;
   logic        man_ack;
   logic        redirect;
   logic [31:0] target;

   int total = 0;
   int bad   = 0;

   if_fetch_unit_if imem_if ();

   assign imem_if.ack   = zw_mode ? imem_if.req : man_ack;
   assign imem_if.rdata = {16'hC0DE, imem_if.addr[15:0]};
   assign next_pc       = redirect ? target : pc_plus4;

   always #5 clk = ~clk;

   if_fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .next_pc      (next_pc),
      .pc_plus4     (pc_plus4),
      .pc           (pc),
      .imem         (imem_if),
      .stall_id     (stall_id),
      .flush        (flush),
      .ifid_valid   (ifid_valid),
      .ifid_pc      (ifid_pc),
      .ifid_instr   (ifid_instr),
      .misalign_exc (misalign_exc)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; zw_mode = 1'b1; man_ack = 1'b0; stall_id = 1'b0;
      flush = 1'b0; redirect = 1'b0; target = 32'h0;
      repeat (3) step();
      total++; if (pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
      total++; if (imem_if.addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=%h", imem_if.addr, 32'h0); end
      total++; if (imem_if.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_if.req); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
      total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL rst_ifid_pc got=%h exp=%h", ifid_pc, 32'h0); end
      total++; if (ifid_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h exp=%h", ifid_instr, 32'h0); end
      total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL rst_exc got=%b exp=0", misalign_exc); end
      total++; if (pc_plus4 !== 32'h4) begin bad++; $display("FAIL rst_pc4 got=%h exp=%h", pc_plus4, 32'h4); end
      rst_n = 1'b1;
   endtask

   task automatic test_sequential();
      total++; if (imem_if.req !== 1'b0) begin bad++; $display("FAIL boot_req got=%b exp=0", imem_if.req); end
      step();
      total++; if (imem_if.req !== 1'b1) begin bad++; $display("FAIL seq_req got=%b exp=1", imem_if.req); end
      total++; if (imem_if.addr !== 32'h0) begin bad++; $display("FAIL seq_addr0 got=%h exp=%h", imem_if.addr, 32'h0); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL seq_valid0 got=%b exp=0", ifid_valid); end
      step();
      total++; if (ifid_valid !== 1'b1) begin bad++; $display("FAIL seq_valid1 got=%b exp=1", ifid_valid); end
      total++; if (ifid_pc !== 32'h0) begin bad++; $display("FAIL seq_ifid_pc0 got=%h exp=%h", ifid_pc, 32'h0); end
      total++; if (ifid_instr !== 32'hC0DE_0000) begin bad++; $display("FAIL seq_instr0 got=%h exp=%h", ifid_instr, 32'hC0DE_0000); end
      total++; if (imem_if.addr !== 32'h4) begin bad++; $display("FAIL seq_addr4 got=%h exp=%h", imem_if.addr, 32'h4); end
      step();
      total++; if (ifid_pc !== 32'h4) begin bad++; $display("FAIL seq_ifid_pc4 got=%h exp=%h", ifid_pc, 32'h4); end
      total++; if (imem_if.addr !== 32'h8) begin bad++; $display("FAIL seq_addr8 got=%h exp=%h", imem_if.addr, 32'h8); end
   endtask

   task automatic test_stall();
      stall_id = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (imem_if.req !== 1'b0) begin bad++; $display("FAIL stall_req[%0d] got=%b exp=0", i, imem_if.req); end
         total++; if (ifid_pc !== 32'h4 || ifid_valid !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%b exp=%h/1", i, ifid_pc, ifid_valid, 32'h4); end
         total++; if (pc !== 32'h8) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, 32'h8); end
      end
      stall_id = 1'b0;
      step();
      total++; if (ifid_pc !== 32'h8) begin bad++; $display("FAIL unstall_ifid_pc got=%h exp=%h", ifid_pc, 32'h8); end
      total++; if (ifid_instr !== 32'hC0DE_0008) begin bad++; $display("FAIL unstall_instr got=%h exp=%h", ifid_instr, 32'hC0DE_0008); end
      total++; if (imem_if.addr !== 32'hC || imem_if.req !== 1'b1) begin bad++; $display("FAIL unstall_req got=%h/%b exp=%h/1", imem_if.addr, imem_if.req, 32'hC); end
   endtask

   task automatic test_flush_drain();
      zw_mode = 1'b0; man_ack = 1'b0;
      step();
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%b exp=0", ifid_valid); end
      flush = 1'b1; redirect = 1'b1; target = 32'h100;
      step();
      flush = 1'b0; redirect = 1'b0;
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL drain_pc got=%h exp=%h", pc, 32'h100); end
      total++; if (imem_if.addr !== 32'hC || imem_if.req !== 1'b1) begin bad++; $display("FAIL drain_addr got=%h/%b exp=%h/1", imem_if.addr, imem_if.req, 32'hC); end
      total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL drain_ifid got=%b/%h exp=0/0", ifid_valid, ifid_instr); end
      step();
      total++; if (imem_if.addr !== 32'hC) begin bad++; $display("FAIL drain_wait_addr got=%h exp=%h", imem_if.addr, 32'hC); end
      man_ack = 1'b1;
      step();
      man_ack = 1'b0;
      total++; if (imem_if.addr !== 32'h100 || imem_if.req !== 1'b1) begin bad++; $display("FAIL drain_done got=%h/%b exp=%h/1", imem_if.addr, imem_if.req, 32'h100); end
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL drain_drop got=%b exp=0", ifid_valid); end
      total++; if (pc !== 32'h100) begin bad++; $display("FAIL drain_pc_hold got=%h exp=%h", pc, 32'h100); end
      zw_mode = 1'b1;
      step();
      total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h100) begin bad++; $display("FAIL refetch got=%b/%h exp=1/%h", ifid_valid, ifid_pc, 32'h100); end
      total++; if (imem_if.addr !== 32'h104) begin bad++; $display("FAIL refetch_addr got=%h exp=%h", imem_if.addr, 32'h104); end
   endtask

   task automatic test_flush_stall();
      stall_id = 1'b1; flush = 1'b1; redirect = 1'b1; target = 32'h200;
      step();
      stall_id = 1'b0; flush = 1'b0; redirect = 1'b0;
      total++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL fs_ifid got=%b/%h exp=0/0", ifid_valid, ifid_instr); end
      total++; if (pc !== 32'h200 || imem_if.addr !== 32'h200) begin bad++; $display("FAIL fs_pc got=%h/%h exp=%h", pc, imem_if.addr, 32'h200); end
      step();
      total++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200) begin bad++; $display("FAIL fs_next got=%b/%h exp=1/%h", ifid_valid, ifid_pc, 32'h200); end
   endtask

   task automatic test_misalign();
      logic [31:0] exp_pc;
      logic        exp_exc;
`ifdef IF_MISALIGN_TRAP_EN
      exp_pc = 32'h180; exp_exc = 1'b1;
`else
      exp_pc = 32'h100; exp_exc = 1'b0;
`endif
      flush = 1'b1; redirect = 1'b1; target = 32'h102;
      step();
      flush = 1'b0; redirect = 1'b0;
      total++; if (pc !== exp_pc) begin bad++; $display("FAIL mis_pc got=%h exp=%h", pc, exp_pc); end
      total++; if (imem_if.addr !== exp_pc) begin bad++; $display("FAIL mis_addr got=%h exp=%h", imem_if.addr, exp_pc); end
      total++; if (misalign_exc !== exp_exc) begin bad++; $display("FAIL mis_exc got=%b exp=%b", misalign_exc, exp_exc); end
      step();
      total++; if (misalign_exc !== 1'b0) begin bad++; $display("FAIL mis_exc_pulse got=%b exp=0", misalign_exc); end
      total++; if (ifid_pc !== exp_pc) begin bad++; $display("FAIL mis_ifid_pc got=%h exp=%h", ifid_pc, exp_pc); end
   endtask

   task automatic test_wrap();
      flush = 1'b1; redirect = 1'b1; target = 32'hFFFF_FFFC;
      step();
      flush = 1'b0; redirect = 1'b0;
      total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc4 got=%h exp=%h", pc_plus4, 32'h0); end
      step();
      total++; if (pc !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h/%h exp=0/%h", pc, ifid_pc, 32'hFFFF_FFFC); end
   endtask

   task automatic test_reset_mid_hold();
      stall_id = 1'b1;
      step();
      total++; if (imem_if.req !== 1'b0) begin bad++; $display("FAIL hold_req got=%b exp=0", imem_if.req); end
      rst_n = 1'b0;
      #1;
      total++; if (pc !== 32'h0 || imem_if.addr !== 32'h0) begin bad++; $display("FAIL mrst_pc got=%h/%h exp=0/0", pc, imem_if.addr); end
      total++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0 || ifid_instr !== 32'h0) begin bad++; $display("FAIL mrst_ifid got=%b/%h/%h exp=0/0/0", ifid_valid, ifid_pc, ifid_instr); end
      total++; if (imem_if.req !== 1'b0 || misalign_exc !== 1'b0) begin bad++; $display("FAIL mrst_req got=%b/%b exp=0/0", imem_if.req, misalign_exc); end
      stall_id = 1'b0; zw_mode = 1'b0; man_ack = 1'b1;
      #3;
      rst_n = 1'b1;
      step();
      man_ack = 1'b0;
      total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL stale_ack got=%b exp=0", ifid_valid); end
      total++; if (imem_if.req !== 1'b1 || imem_if.addr !== 32'h0) begin bad++; $display("FAIL post_rst_req got=%b/%h exp=1/0", imem_if.req, imem_if.addr); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_flush_drain();
      test_flush_stall();
      test_misalign();
      test_wrap();
      test_reset_mid_hold();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
